// File: rtl/sha256_msg_schedule_if.sv
// Block-load and schedule-word handshake bundle for the SHA-256 message scheduler.
// master = upstream/round-stage side, slave = scheduler side.
interface sha256_msg_schedule_if;
    logic         sched_clr;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;

    modport master (
        output sched_clr, blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_out, w_idx, w_last
    );

    modport slave (
        input  sched_clr, blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_out, w_idx, w_last
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block, streams W[0..63] from a 16-word window.
// Optional stall counter output enabled by defining SHA256_SCHED_STALL_CNT_EN.
module sha256_msg_schedule (
    input  logic                       clk,
    input  logic                       n_rst,
    sha256_msg_schedule_if.slave       bus
`ifdef SHA256_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_win      [16];
    logic [31:0] w_win_next [16];
    logic [31:0] w_blk_word [16];
    logic [5:0]  r_t;
    logic [5:0]  w_t_next;
    logic        w_load;
    logic        w_blk_ready;
    logic [31:0] w_new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // W0 sits in the most significant word of the block
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
            assign w_blk_word[gi] = bus.blk_data[511 - 32*gi -: 32];
        end
    endgenerate

    assign w_new_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_win_next   = r_win;
        w_blk_ready  = 1'b0;
        w_load       = 1'b0;
        if (bus.sched_clr) begin
            w_state_next = ST_IDLE;
            w_t_next     = 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_blk_ready = 1'b1;
                    w_load      = bus.blk_valid;
                end
                ST_RUN: begin
                    if (bus.w_ready) begin
                        if (r_t == 6'd63) begin
                            // last word leaving: a waiting block may load in the same edge
                            w_blk_ready = 1'b1;
                            w_t_next    = 6'd0;
                            if (bus.blk_valid) begin
                                w_load = 1'b1;
                            end else begin
                                w_state_next = ST_IDLE;
                            end
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                w_win_next[i] = r_win[i+1];
                            end
                            w_win_next[15] = w_new_word;
                            w_t_next       = r_t + 6'd1;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
        if (w_load) begin
            w_win_next   = w_blk_word;
            w_t_next     = 6'd0;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= w_win_next[i];
            end
        end
    end

    assign bus.blk_ready = w_blk_ready;
    assign bus.w_valid   = (r_state == ST_RUN);
    assign bus.w_out     = r_win[0];
    assign bus.w_idx     = r_t;
    assign bus.w_last    = (r_state == ST_RUN) && (r_t == 6'd63);

`ifdef SHA256_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!n_rst || bus.sched_clr || w_load) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == ST_RUN) && !bus.w_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: reference W[0..63] from the textbook recurrence,
// a negedge monitor compares every presented word against the expected queue.
module tb_sha256_msg_schedule;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic clk;
    logic n_rst;
    sha256_msg_schedule_if bus ();
`ifdef SHA256_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    sha256_msg_schedule dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
`ifdef SHA256_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    exp_t        exp_q[$];
    logic [31:0] seen [64];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [511:0] abc_blk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule straight from the SHA-256 recurrence over a flat array
    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) begin
            e.w = w[t]; e.idx = 6'(t); e.last = (t == 63);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b = '0;
        for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
        return b;
    endfunction

    // Monitor: compare whatever the DUT presents against the head of the queue
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
        end else begin
            if (bus.sched_clr) chk("clr_blk_ready", 32'(bus.blk_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("idle_w_valid", 32'(bus.w_valid), 32'd0);
            end else begin
                chk("w_valid", 32'(bus.w_valid), 32'd1);
                if (bus.w_valid) begin
                    chk("w_out", bus.w_out, exp_q[0].w);
                    chk("w_idx", 32'(bus.w_idx), 32'(exp_q[0].idx));
                    chk("w_last", 32'(bus.w_last), 32'(exp_q[0].last));
                    if (bus.w_ready && !bus.sched_clr) begin
                        seen[bus.w_idx] = bus.w_out;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.sched_clr) exp_q.delete();
        end
    end

    task automatic load_block(input logic [511:0] blk);
        bit ok = 0;
        @(posedge clk); #1;
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.blk_ready) begin ok = 1; break; end
        end
        chk("load_handshake", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (ok) push_block(blk);
        bus.blk_valid = 1'b0;
    endtask

    task automatic wait_idx(input int n, output int cycles);
        bit ok = 0;
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.w_valid && bus.w_idx == 6'(n)) begin ok = 1; break; end
        end
        if (!ok) chk("wait_idx_timeout", 32'(n), 32'hFFFF_FFFF);
    endtask

    task automatic drain(input bit rnd);
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            bus.w_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        bus.w_ready = 1'b1;
        chk("drain", 32'(ok), 32'd1);
    endtask

    initial begin
        int c;
        abc_blk = {32'h61626380, 448'd0, 32'h00000018};
        n_rst = 1'b0;
        bus.sched_clr = 1'b0;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
        chk("rst_w_out", bus.w_out, 32'd0);
        chk("rst_w_idx", 32'(bus.w_idx), 32'd0);
        chk("rst_w_last", 32'(bus.w_last), 32'd0);
        chk("rst_blk_ready", 32'(bus.blk_ready), 32'd1);

        // abc block, continuous consumption
        load_block(abc_blk);
        wait_idx(63, c);
        chk("abc_cycles", 32'(c), 32'd64);
        drain(0);
        chk("abc_w16", seen[16], 32'h61626380);
        chk("abc_w17", seen[17], 32'h000F0000);
        chk("abc_w18", seen[18], 32'h7DA86405);

        // 5-cycle stall at t=20
        load_block(abc_blk);
        wait_idx(19, c);
        @(posedge clk); #1 bus.w_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.w_ready = 1'b1;
        drain(0);
`ifdef SHA256_SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

        // back-to-back block on the last accept
        load_block(rand_blk());
        wait_idx(62, c);
        load_block(rand_blk());
        wait_idx(0, c);
        chk("b2b_gap", 32'(c), 32'd1);
        drain(0);
        @(negedge clk);
        chk("post_last_idle", 32'(bus.w_valid), 32'd0);

        // abort at t=30 with a competing block
        load_block(rand_blk());
        wait_idx(29, c);
        @(posedge clk); #1;
        bus.sched_clr = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_data  = rand_blk();
        @(negedge clk);
        chk("clr_ready_low", 32'(bus.blk_ready), 32'd0);
        @(posedge clk); #1;
        bus.sched_clr = 1'b0;
        bus.blk_valid = 1'b0;
        @(negedge clk);
        chk("clr_w_valid", 32'(bus.w_valid), 32'd0);
        load_block(rand_blk());
        drain(1);

        // reset mid-block at t=40, then reload
        load_block(abc_blk);
        wait_idx(39, c);
        @(posedge clk); #1 n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_w_valid", 32'(bus.w_valid), 32'd0);
        chk("mid_rst_w_out", bus.w_out, 32'd0);
        chk("mid_rst_w_idx", 32'(bus.w_idx), 32'd0);
        chk("mid_rst_w_last", 32'(bus.w_last), 32'd0);
        @(posedge clk); #1 n_rst = 1'b1;
        load_block(abc_blk);
        drain(0);
        chk("reload_w18", seen[18], 32'h7DA86405);

        // random blocks under random back-pressure
        for (int k = 0; k < 4; k++) begin
            load_block(rand_blk());
            drain(1);
        end

        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
